// File: rtl/obstacle_pkg.sv
// -----------------------------------------------------------------------------
// obstacle_pkg
// Shared types for the obstacle scheduling slice: obstacle word field widths,
// the obstacle type encoding, the scheduler state encoding and the layout of
// one frame-list entry.
// -----------------------------------------------------------------------------
package obstacle_pkg;

  localparam int TYPE_W     = 3;
  localparam int LANE_W     = 2;
  localparam int DEPTH_W    = 11;
  localparam int OBSTACLE_W = TYPE_W + LANE_W + DEPTH_W;  // 16
  localparam int ENTRY_W    = OBSTACLE_W + 1;              // first_row + word

  typedef enum logic [TYPE_W-1:0] {
    NONE   = 3'b000,
    JUMP   = 3'b001,
    DUCK   = 3'b010,
    MIDDLE = 3'b011,
    TRAIN  = 3'b100,
    RAMP   = 3'b101,
    CAR    = 3'b110
  } obstacle_type_e;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    SERVE
  } sched_state_e;

  // One captured generator word as stored in the frame list.
  typedef struct packed {
    logic                  first_row;
    logic [OBSTACLE_W-1:0] obstacle;
  } list_entry_t;

endpackage

// File: rtl/obstacle_list_buffer.sv
// -----------------------------------------------------------------------------
// obstacle_list_buffer
// DEPTH x ENTRY_W frame-list storage with one synchronous write port and one
// asynchronous read port.
//
// Ports:
//   clk      in   system clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   entry to store {first_row, obstacle}
//   rd_addr  in   read address (out-of-range reads return 0)
//   rd_data  out  entry at rd_addr, combinational
// -----------------------------------------------------------------------------
module obstacle_list_buffer #(
  parameter int DEPTH   = 48,
  parameter int ADDR_W  = 6,
  parameter int ENTRY_W = 17
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; every entry is written
  // before it can be read back, so a reset would only cost a wide clear path.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read pointer legitimately reaches DEPTH once a full list is drained.
  assign rd_data = (rd_addr < ADDR_W'(DEPTH)) ? mem[rd_addr] : '0;

endmodule

// File: rtl/obstacle_frame_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_frame_scheduler
// Activates obstacle_generator once every FRAMES_PER_STEP frames, captures its
// obstacle stream into a frame list and replays that list to the renderer over
// a valid/ready handshake. A frame arriving while a step is still in progress
// is flagged as an overrun and otherwise ignored.
//
// Optional build macro: OBSTACLE_SCHED_STATS_EN enables the stat_peak and
// stat_overruns counters; when undefined both ports are tied to zero.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   new_frame      frame-start pulse
//   pause          masks new_frame completely
//   og_activate    registered one-cycle activate pulse to the generator
//   og_valid       generator word valid
//   og_first_row   generator first_row flag
//   og_obstacle    generator word {type, lane, depth}
//   og_done        generator idle level
//   out_valid      list entry available (SERVE only)
//   out_ready      renderer accepts entry
//   out_obstacle   entry word
//   out_first_row  entry first_row flag
//   out_last       final entry of the list
//   frame_done     one-cycle pulse after the list is fully served
//   overrun        one-cycle pulse for a frame arriving outside IDLE
//   dropped        sticky for the step: generator overflowed the list
//   stat_peak      largest list size since reset
//   stat_overruns  saturating overrun count
// -----------------------------------------------------------------------------
module obstacle_frame_scheduler
  import obstacle_pkg::*;
#(
  parameter int MAX_OBSTACLES   = 48,
  parameter int FRAMES_PER_STEP = 1,
  parameter int DONE_GUARD      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_frame,
  input  logic        pause,
  output logic        og_activate,
  input  logic        og_valid,
  input  logic        og_first_row,
  input  logic [15:0] og_obstacle,
  input  logic        og_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_obstacle,
  output logic        out_first_row,
  output logic        out_last,
  output logic        frame_done,
  output logic        overrun,
  output logic        dropped,
  output logic [6:0]  stat_peak,
  output logic [7:0]  stat_overruns
);

  localparam int PTR_W   = $clog2(MAX_OBSTACLES + 1);
  localparam int FC_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int GUARD_W = (DONE_GUARD > 0) ? $clog2(DONE_GUARD + 1) : 1;

  localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(MAX_OBSTACLES);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [FC_W-1:0]    FC_ONE     = FC_W'(1);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(DONE_GUARD);
  localparam logic [GUARD_W-1:0] GUARD_ONE  = GUARD_W'(1);

  sched_state_e       state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   count;
  logic [FC_W-1:0]    frame_cnt;
  logic [GUARD_W-1:0] guard;

  list_entry_t        wr_entry;
  list_entry_t        rd_entry;

  logic               trigger;
  logic               wr_accept;
  logic               done_honoured;
  logic [PTR_W-1:0]   next_count;
  logic               serve_valid;
  logic               serve_last;
  logic               transfer;

  assign trigger       = new_frame & ~pause;
  assign wr_accept     = (state == GEN) & og_valid & (wr_ptr != PTR_MAX);
  // og_done is a level that is still high from the previous step right after
  // activation; the guard window masks it until the generator has left DONE.
  assign done_honoured = (state == GEN) & og_done & (guard == '0);
  // A word arriving with the honoured done is part of the list.
  assign next_count    = wr_ptr + (wr_accept ? PTR_ONE : '0);
  assign serve_valid   = (state == SERVE) & (rd_ptr < count);
  assign serve_last    = serve_valid & (rd_ptr == count - PTR_ONE);
  assign transfer      = serve_valid & out_ready;

  assign wr_entry.first_row = og_first_row;
  assign wr_entry.obstacle  = og_obstacle;

  obstacle_list_buffer #(
    .DEPTH   (MAX_OBSTACLES),
    .ADDR_W  (PTR_W),
    .ENTRY_W (ENTRY_W)
  ) u_list (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Data is gated by valid so every output reads 0 outside an active transfer
  // window, including straight after reset when the storage is undefined.
  assign out_valid     = serve_valid;
  assign out_last      = serve_last;
  assign out_obstacle  = serve_valid ? rd_entry.obstacle  : '0;
  assign out_first_row = serve_valid ? rd_entry.first_row : 1'b0;

  // NOTE: all state below is updated with non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      frame_cnt   <= '0;
      guard       <= '0;
      og_activate <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      og_activate <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= trigger & (state != IDLE);

      case (state)
        IDLE: begin
          if (trigger) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt   <= '0;
              og_activate <= 1'b1;
              wr_ptr      <= '0;
              dropped     <= 1'b0;
              guard       <= GUARD_INIT;
              state       <= GEN;
            end else begin
              frame_cnt <= frame_cnt + FC_ONE;
            end
          end
        end

        GEN: begin
          if (guard != '0) guard <= guard - GUARD_ONE;
          if (wr_accept)     wr_ptr  <= wr_ptr + PTR_ONE;
          else if (og_valid) dropped <= 1'b1;
          if (done_honoured) begin
            count  <= next_count;
            rd_ptr <= '0;
            state  <= SERVE;
          end
        end

        SERVE: begin
          if (count == '0) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else if (transfer) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            if (serve_last) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef OBSTACLE_SCHED_STATS_EN
  logic [6:0] peak_q;
  logic [7:0] overruns_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q     <= '0;
      overruns_q <= '0;
    end else begin
      if (done_honoured && (7'(next_count) > peak_q)) peak_q <= 7'(next_count);
      if (trigger && (state != IDLE) && (overruns_q != 8'hFF))
        overruns_q <= overruns_q + 8'd1;
    end
  end

  assign stat_peak     = peak_q;
  assign stat_overruns = overruns_q;
`else
  assign stat_peak     = '0;
  assign stat_overruns = '0;
`endif

endmodule

// File: tb/tb_obstacle_frame_scheduler.sv
`timescale 1ns/1ps
module tb_obstacle_frame_scheduler;

  localparam int MAXO = 48;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, new_frame, pause, og_valid, og_first_row, og_done, out_ready;
  logic [15:0] og_obstacle;

  logic        og_activate, out_valid, out_first_row, out_last, frame_done, overrun, dropped;
  logic [15:0] out_obstacle;
  logic [6:0]  stat_peak;
  logic [7:0]  stat_overruns;

  logic        c3_og_activate, c3_out_valid, c3_out_first_row, c3_out_last;
  logic        c3_frame_done, c3_overrun, c3_dropped;
  logic [15:0] c3_out_obstacle;
  logic [6:0]  c3_stat_peak;
  logic [7:0]  c3_stat_overruns;

  int vectors     = 0;
  int miscompares = 0;
  int peak_model  = 0;
  int ovr_model   = 0;

  // Main instance: one activation per frame, driven by the generator model.
  obstacle_frame_scheduler #(.MAX_OBSTACLES(MAXO), .FRAMES_PER_STEP(1), .DONE_GUARD(2)) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .pause(pause),
    .og_activate(og_activate), .og_valid(og_valid), .og_first_row(og_first_row),
    .og_obstacle(og_obstacle), .og_done(og_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_obstacle(out_obstacle), .out_first_row(out_first_row),
    .out_last(out_last), .frame_done(frame_done), .overrun(overrun), .dropped(dropped),
    .stat_peak(stat_peak), .stat_overruns(stat_overruns)
  );

  // Second instance: three frames per step, generator permanently idle.
  obstacle_frame_scheduler #(.MAX_OBSTACLES(MAXO), .FRAMES_PER_STEP(3), .DONE_GUARD(2)) dut3 (
    .clk(clk), .rst(rst), .new_frame(new_frame), .pause(pause),
    .og_activate(c3_og_activate), .og_valid(1'b0), .og_first_row(1'b0),
    .og_obstacle(16'h0000), .og_done(1'b1), .out_valid(c3_out_valid),
    .out_ready(out_ready), .out_obstacle(c3_out_obstacle), .out_first_row(c3_out_first_row),
    .out_last(c3_out_last), .frame_done(c3_frame_done), .overrun(c3_overrun),
    .dropped(c3_dropped), .stat_peak(c3_stat_peak), .stat_overruns(c3_stat_overruns)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [40:0] dut_outs();
    return {og_activate, out_valid, out_obstacle, out_first_row, out_last,
            frame_done, overrun, dropped, stat_peak, stat_overruns};
  endfunction

  function automatic logic [40:0] dut3_outs();
    return {c3_og_activate, c3_out_valid, c3_out_obstacle, c3_out_first_row, c3_out_last,
            c3_frame_done, c3_overrun, c3_dropped, c3_stat_peak, c3_stat_overruns};
  endfunction

  // One complete game step: frame pulse, generator emits n words (done level
  // held high for done_hold cycles after activation first), then the list is
  // drained by a randomly stalling renderer and checked against a queue.
  task automatic run_step(input int n, input int done_hold, input bit stall, input bit probe);
    logic [16:0] words[$];
    logic [16:0] exp_q[$];
    logic [16:0] w, held;
    int c, idx, it, fd, ovr, act, post, stall_left;
    bit last_drv, have_hold, stall_done;

    for (int i = 0; i < n; i++) begin
      w = 17'($urandom);
      words.push_back(w);
      if (i < MAXO) exp_q.push_back(w);
    end

    new_frame = 1'b1;
    og_valid  = 1'b0;
    tick();
    new_frame = 1'b0;
    og_done   = (done_hold >= 1);
    @(negedge clk);
    vectors++;
    if (og_activate !== 1'b1) begin
      miscompares++;
      $display("FAIL activate_latency: og_activate=%b required 1", og_activate);
    end
    tick();

    // Generator model; emission starts once the guard window is over.
    c = 2;
    idx = 0;
    forever begin
      og_done  = (c <= done_hold);
      og_valid = 1'b0;
      last_drv = 1'b0;
      if (c > 2 && c > done_hold) begin
        if (idx < n) begin
          if ($urandom_range(0, 3) != 0) begin
            og_valid = 1'b1;
            {og_first_row, og_obstacle} = words[idx];
            idx++;
            if (idx == n && $urandom_range(0, 1) == 1) begin
              og_done  = 1'b1;
              last_drv = 1'b1;
            end
          end
        end else begin
          og_done  = 1'b1;
          last_drv = 1'b1;
        end
      end
      tick();
      c++;
      if (last_drv) break;
      if (c > 2000) begin
        miscompares++;
        $display("FAIL gen_timeout: cycles=%0d required <2000", c);
        break;
      end
    end
    og_valid = 1'b0;
    og_done  = 1'b1;

    // Renderer side.
    it = 0; fd = 0; ovr = 0; act = 0; post = 0; stall_left = 0;
    have_hold = 1'b0; stall_done = 1'b0; held = '0;
    while (it < 400) begin
      new_frame = probe && (it == 1);
      if (probe && it < 3) out_ready = 1'b0;
      else if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (it == 0) begin
        vectors++;
        if (dropped !== (n > MAXO)) begin
          miscompares++;
          $display("FAIL dropped_flag: dropped=%b required %b", dropped, (n > MAXO));
        end
      end
      if (og_activate === 1'b1) act++;
      if (overrun === 1'b1) ovr++;
      if (frame_done === 1'b1) fd++;
      if (probe && it == 2) begin
        vectors++;
        if (overrun !== 1'b1) begin
          miscompares++;
          $display("FAIL overrun_pulse: overrun=%b required 1", overrun);
        end
      end
      if (have_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || {out_first_row, out_obstacle} !== held) begin
          miscompares++;
          $display("FAIL stall_stable: valid=%b data=%h required valid=1 data=%h",
                   out_valid, {out_first_row, out_obstacle}, held);
        end
      end
      have_hold = (out_valid === 1'b1) && !out_ready;
      held      = {out_first_row, out_obstacle};
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_entry: data=%h required no entry", held);
        end else begin
          w = exp_q.pop_front();
          if (held !== w || out_last !== (exp_q.size() == 0)) begin
            miscompares++;
            $display("FAIL entry_data: data=%h last=%b required data=%h last=%b",
                     held, out_last, w, (exp_q.size() == 0));
          end
          if (stall && !stall_done && exp_q.size() > 0) begin
            stall_left = 5;
            stall_done = 1'b1;
          end
        end
      end else if (out_valid !== 1'b0 && out_valid !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL out_valid_x: out_valid=%b required 0/1", out_valid);
      end
      tick();
      it++;
      if (fd > 0) begin
        post++;
        if (post > 3) break;
      end
    end
    new_frame = 1'b0;

    vectors++;
    if (fd != 1) begin
      miscompares++;
      $display("FAIL frame_done_count: pulses=%0d required 1", fd);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL entries_lost: remaining=%0d required 0", exp_q.size());
    end
    vectors++;
    if (ovr != (probe ? 1 : 0) || act != 0) begin
      miscompares++;
      $display("FAIL serve_side_pulses: overruns=%0d activates=%0d required %0d and 0",
               ovr, act, (probe ? 1 : 0));
    end

    if (((n > MAXO) ? MAXO : n) > peak_model) peak_model = (n > MAXO) ? MAXO : n;
    if (probe) ovr_model++;
    vectors++;
`ifdef OBSTACLE_SCHED_STATS_EN
    if (stat_peak !== 7'(peak_model) || stat_overruns !== 8'(ovr_model)) begin
      miscompares++;
      $display("FAIL stats: peak=%0d overruns=%0d required %0d %0d",
               stat_peak, stat_overruns, peak_model, ovr_model);
    end
`else
    if (stat_peak !== 7'd0 || stat_overruns !== 8'd0) begin
      miscompares++;
      $display("FAIL stats_off: peak=%0d overruns=%0d required 0 0", stat_peak, stat_overruns);
    end
`endif
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    peak_model = 0;
    ovr_model  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    vectors++;
    if (dut_outs() !== '0 || dut3_outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: main=%h c3=%h required 0 0", dut_outs(), dut3_outs());
    end
    tick();
    rst = 1'b0;
    peak_model = 0;
    ovr_model  = 0;
    tick();
  endtask

  task automatic test_basic();        run_step(3, 0, 1'b0, 1'b0); endtask
  task automatic test_stall();        run_step(9, 0, 1'b1, 1'b0); endtask
  task automatic test_done_guard();   run_step(4, 2, 1'b0, 1'b0); endtask
  task automatic test_empty();        run_step(0, 2, 1'b0, 1'b0); endtask
  task automatic test_overrun();      run_step(6, 0, 1'b0, 1'b1); endtask

  task automatic test_overflow();
    run_step(50, 0, 1'b0, 1'b0);
    run_step(5, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(0, 52);
      run_step(n, $urandom_range(0, 2), $urandom_range(0, 1) == 1,
               (n > 0) && ($urandom_range(0, 2) == 0));
    end
  endtask

  task automatic test_pause_frames();
    int unpaused, act1, act3, ovr_seen;
    bit p;
    apply_reset();
    og_valid = 1'b0;
    og_done  = 1'b1;
    unpaused = 0;
    for (int f = 0; f < 9; f++) begin
      p = (f == 2) || ($urandom_range(0, 3) == 0);
      pause     = p;
      new_frame = 1'b1;
      tick();
      new_frame = 1'b0;
      pause     = 1'b0;
      act1 = 0; act3 = 0; ovr_seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (og_activate === 1'b1) act1++;
        if (c3_og_activate === 1'b1) act3++;
        if (overrun === 1'b1 || c3_overrun === 1'b1) ovr_seen++;
        tick();
      end
      if (!p) unpaused++;
      vectors++;
      if (act1 != (p ? 0 : 1) || act3 != ((!p && unpaused % 3 == 0) ? 1 : 0) || ovr_seen != 0) begin
        miscompares++;
        $display("FAIL frame_count f%0d: act1=%0d act3=%0d ovr=%0d required %0d %0d 0",
                 f, act1, act3, ovr_seen, (p ? 0 : 1), ((!p && unpaused % 3 == 0) ? 1 : 0));
      end
    end
  endtask

  task automatic test_reset_mid_gen();
    int fd;
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    og_done   = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      og_valid = 1'b1;
      {og_first_row, og_obstacle} = 17'($urandom);
      tick();
    end
    og_valid = 1'b0;
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++;
    if (dut_outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_gen: outputs=%h required 0", dut_outs());
    end
    tick();
    rst = 1'b0;
    og_done = 1'b1;
    peak_model = 0;
    ovr_model  = 0;
    fd = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1 || out_valid === 1'b1) fd++;
      tick();
    end
    vectors++;
    if (fd != 0) begin
      miscompares++;
      $display("FAIL abandoned_list: activity=%0d required 0", fd);
    end
    run_step(7, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; new_frame = 1'b0; pause = 1'b0; og_valid = 1'b0;
    og_first_row = 1'b0; og_obstacle = '0; og_done = 1'b1; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_done_guard();
    test_overflow();
    test_overrun();
    test_empty();
    test_back_to_back();
    test_pause_frames();
    test_reset_mid_gen();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
